// File: rtl/cios_gamma_row.sv
// CIOS inner row: streams T[j] + m*p[j] + C, folds in T[s], T[s+1] and emits the shifted words T'[0..NWORDS].
// Latency: a word accepted at edge k accumulates at edge k+MUL_STAGES+1. No output backpressure; in_ready drops after NWORDS words.
module cios_gamma_row #(
    parameter int WIDTH      = 32,
    parameter int NWORDS     = 8,
    parameter int MUL_STAGES = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             m,
    input  logic [WIDTH-1:0]             t_hi,
    input  logic [WIDTH-1:0]             t_hi1,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             t_in,
    input  logic [WIDTH-1:0]             p_in,
    output logic                         out_valid,
    output logic [$clog2(NWORDS+1)-1:0]  out_idx,
    output logic [WIDTH-1:0]             out_word,
    output logic                         busy,
    output logic                         done,
    output logic                         lsw_err
);
    localparam int IW = $clog2(NWORDS+1);
    localparam int W2 = 2 * WIDTH;
    localparam logic [IW-1:0] NW   = IW'(NWORDS);
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN1, FIN2} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0] m_q, thi_q, thi1_q, c_q;
    logic             c1_q, lsw_err_q, busy_q;
    logic [IW-1:0]    acc_cnt_q, acc_j_q;
    logic             in_vld_q;
    logic [WIDTH-1:0] in_t_q, in_p_q;
    logic [W2-1:0]    prod_q [MUL_STAGES];
    logic [WIDTH-1:0] pt_q   [MUL_STAGES];
    logic             pv_q   [MUL_STAGES];

    logic             out_valid_q, out_valid_d, done_q, done_d;
    logic [IW-1:0]    out_idx_q, out_idx_d;
    logic [WIDTH-1:0] out_word_q, out_word_d;
    logic [W2-1:0]    sum;
    logic [WIDTH:0]   sum1;
    logic             acc_fire;

    assign in_ready  = (state_q == RUN) && (acc_cnt_q < NW);
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_word  = out_word_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign lsw_err   = lsw_err_q;

    always_comb begin
        sum         = prod_q[MUL_STAGES-1] + W2'(pt_q[MUL_STAGES-1]) + W2'(c_q);
        sum1        = {1'b0, thi_q} + {1'b0, c_q};
        acc_fire    = pv_q[MUL_STAGES-1] && (state_q == RUN);
        state_d     = state_q;
        out_valid_d = 1'b0;
        out_idx_d   = '0;
        out_word_d  = '0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (acc_fire) begin
                    // Word 0's low half is the discarded LSW
                    if (acc_j_q != '0) begin
                        out_valid_d = 1'b1;
                        out_idx_d   = acc_j_q - 1'b1;
                        out_word_d  = sum[WIDTH-1:0];
                    end
                    if (acc_j_q == LAST) state_d = FIN1;
                end
            end
            FIN1: begin
                out_valid_d = 1'b1;
                out_idx_d   = LAST;
                out_word_d  = sum1[WIDTH-1:0];
                state_d     = FIN2;
            end
            FIN2: begin
                out_valid_d = 1'b1;
                out_idx_d   = NW;
                out_word_d  = thi1_q + WIDTH'(c1_q);
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            m_q         <= '0;
            thi_q       <= '0;
            thi1_q      <= '0;
            c_q         <= '0;
            c1_q        <= 1'b0;
            lsw_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            acc_cnt_q   <= '0;
            acc_j_q     <= '0;
            in_vld_q    <= 1'b0;
            in_t_q      <= '0;
            in_p_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_word_q  <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                prod_q[i] <= '0;
                pt_q[i]   <= '0;
                pv_q[i]   <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_word_q  <= out_word_d;
            done_q      <= done_d;
            if (state_q == IDLE && start) begin
                m_q       <= m;
                thi_q     <= t_hi;
                thi1_q    <= t_hi1;
                c_q       <= '0;
                lsw_err_q <= 1'b0;
                acc_cnt_q <= '0;
                acc_j_q   <= '0;
            end
            in_vld_q <= in_valid && in_ready;
            if (in_valid && in_ready) begin
                in_t_q    <= t_in;
                in_p_q    <= p_in;
                acc_cnt_q <= acc_cnt_q + 1'b1;
            end
            prod_q[0] <= W2'(m_q) * W2'(in_p_q);
            pt_q[0]   <= in_t_q;
            pv_q[0]   <= in_vld_q;
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
                pt_q[i]   <= pt_q[i-1];
                pv_q[i]   <= pv_q[i-1];
            end
            if (acc_fire) begin
                c_q     <= sum[W2-1:WIDTH];
                acc_j_q <= acc_j_q + 1'b1;
                if (acc_j_q == '0) lsw_err_q <= |sum[WIDTH-1:0];
            end
            if (state_q == FIN1) c1_q <= sum1[WIDTH];
        end
    end
endmodule

// File: tb/tb_cios_gamma_row.sv
// Bench for cios_gamma_row: directed rows on two NWORDS=2 instances (1 and 3 multiplier stages)
// plus randomized NWORDS=8 rows compared against a whole-number reference (T + m*P) >> WIDTH.
module tb_cios_gamma_row;
    typedef logic [7:0] wv_t [9];
    typedef struct packed { logic d; logic [3:0] i; logic [7:0] w; } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_s, start_c, iv_s, iv_c;
    logic [7:0] m, t_hi, t_hi1, t_in, p_in;
    logic       a_ir, a_ov, a_busy, a_done, a_lerr;
    logic [1:0] a_idx;
    logic [7:0] a_w;
    logic       b_ir, b_ov, b_busy, b_done, b_lerr;
    logic [1:0] b_idx;
    logic [7:0] b_w;
    logic       c_ir, c_ov, c_busy, c_done, c_lerr;
    logic [3:0] c_idx;
    logic [7:0] c_w;

    cios_gamma_row #(.WIDTH(8), .NWORDS(2), .MUL_STAGES(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_s), .m(m), .t_hi(t_hi), .t_hi1(t_hi1),
        .in_valid(iv_s), .in_ready(a_ir), .t_in(t_in), .p_in(p_in), .out_valid(a_ov),
        .out_idx(a_idx), .out_word(a_w), .busy(a_busy), .done(a_done), .lsw_err(a_lerr));
    cios_gamma_row #(.WIDTH(8), .NWORDS(2), .MUL_STAGES(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_s), .m(m), .t_hi(t_hi), .t_hi1(t_hi1),
        .in_valid(iv_s), .in_ready(b_ir), .t_in(t_in), .p_in(p_in), .out_valid(b_ov),
        .out_idx(b_idx), .out_word(b_w), .busy(b_busy), .done(b_done), .lsw_err(b_lerr));
    cios_gamma_row #(.WIDTH(8), .NWORDS(8), .MUL_STAGES(2)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .m(m), .t_hi(t_hi), .t_hi1(t_hi1),
        .in_valid(iv_c), .in_ready(c_ir), .t_in(t_in), .p_in(p_in), .out_valid(c_ov),
        .out_idx(c_idx), .out_word(c_w), .busy(c_busy), .done(c_done), .lsw_err(c_lerr));

    int   n_cmp = 0, n_err = 0, cyc = 0;
    int   done_cyc_a, done_cyc_b, acc_cyc;
    ent_t qa[$], qb[$], qc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_ov) qa.push_back({a_done, 2'b00, a_idx, a_w});
        if (b_ov) qb.push_back({b_done, 2'b00, b_idx, b_w});
        if (c_ov) qc.push_back({c_done, c_idx, c_w});
        if (a_done) done_cyc_a = cyc;
        if (b_done) done_cyc_b = cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the row is one big-number update T' = (T + m*P) >> WIDTH, top word truncated
    function automatic void ref_row(input int n, input logic [7:0] mm, input logic [7:0] th,
                                    input logic [7:0] th1, input logic [7:0] p [8],
                                    input logic [7:0] t [8], output wv_t w, output logic lerr);
        logic [127:0] tf, pf, r;
        tf = '0;
        pf = '0;
        for (int j = 0; j < n; j++) begin
            tf = tf | (128'(t[j]) << (8 * j));
            pf = pf | (128'(p[j]) << (8 * j));
        end
        tf = tf | (128'(th) << (8 * n)) | (128'(th1) << (8 * (n + 1)));
        r = tf + 128'(mm) * pf;
        lerr = (r[7:0] != 8'h00);
        for (int k = 0; k < 9; k++) w[k] = (k <= n) ? 8'(r >> (8 * (k + 1))) : 8'h00;
    endfunction

    task automatic check_row(input string tag, input ent_t q [$], input int n, input wv_t e);
        check({tag, " count"}, q.size(), n + 1);
        for (int k = 0; k <= n && k < q.size(); k++) begin
            check($sformatf("%s idx%0d", tag, k), q[k].i, k);
            check($sformatf("%s word%0d", tag, k), q[k].w, e[k]);
            check($sformatf("%s done%0d", tag, k), q[k].d, (k == n));
        end
    endtask

    task automatic row_s(input logic [7:0] mm, input logic [7:0] th, input logic [7:0] th1,
                         input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] t0,
                         input logic [7:0] t1, input int gap, input bit poke);
        logic [7:0] pv [2];
        logic [7:0] tv [2];
        logic acc;
        int tmo;
        pv = '{p0, p1};
        tv = '{t0, t1};
        qa.delete();
        qb.delete();
        m = mm; t_hi = th; t_hi1 = th1; start_s = 1'b1;
        step();
        start_s = 1'b0;
        for (int j = 0; j < 2; j++) begin
            iv_s = 1'b1; t_in = tv[j]; p_in = pv[j];
            if (poke && j == 1) begin start_s = 1'b1; m = 8'h55; end
            acc = 1'b0;
            tmo = 0;
            while (!acc && tmo < 20) begin acc = a_ir && b_ir; step(); tmo++; end
            check($sformatf("accept w%0d", j), acc, 1);
            if (j == 0) acc_cyc = cyc;
            iv_s = 1'b0; start_s = 1'b0;
            if (j == 0) repeat (gap) step();
        end
        tmo = 0;
        while (!(qa.size() >= 3 && qb.size() >= 3) && tmo < 40) begin step(); tmo++; end
        repeat (3) step();
    endtask

    task automatic row_c(input bit zero_lsw);
        logic [7:0] p [8];
        logic [7:0] t [8];
        logic [7:0] mm, th, th1;
        wv_t e;
        logic lerr, acc;
        int tmo;
        for (int j = 0; j < 8; j++) begin p[j] = 8'($urandom); t[j] = 8'($urandom); end
        mm = 8'($urandom); th = 8'($urandom); th1 = 8'($urandom);
        if (zero_lsw) begin
            p[0] = p[0] | 8'h01;
            for (int k = 0; k < 256; k++)
                if (8'(t[0] + 8'(k) * p[0]) == 8'h00) mm = 8'(k);
        end
        ref_row(8, mm, th, th1, p, t, e, lerr);
        qc.delete();
        m = mm; t_hi = th; t_hi1 = th1; start_c = 1'b1;
        step();
        start_c = 1'b0;
        for (int j = 0; j < 8; j++) begin
            repeat ($urandom_range(0, 2)) step();
            iv_c = 1'b1; t_in = t[j]; p_in = p[j];
            acc = 1'b0;
            tmo = 0;
            while (!acc && tmo < 20) begin acc = c_ir; step(); tmo++; end
            check($sformatf("rnd accept w%0d", j), acc, 1);
            iv_c = 1'b0;
        end
        tmo = 0;
        while (qc.size() < 9 && tmo < 60) begin step(); tmo++; end
        repeat (3) step();
        check_row("rnd", qc, 8, e);
        check("rnd lsw_err", c_lerr, lerr);
    endtask

    initial begin
        wv_t e;
        rst = 1'b1; start_s = 1'b0; start_c = 1'b0; iv_s = 1'b0; iv_c = 1'b0;
        m = '0; t_hi = '0; t_hi1 = '0; t_in = '0; p_in = '0;
        repeat (2) @(negedge clk);
        check("rst out_valid", a_ov, 0);
        check("rst out_idx", a_idx, 0);
        check("rst out_word", a_w, 0);
        check("rst busy", a_busy, 0);
        check("rst done", a_done, 0);
        check("rst lsw_err", a_lerr, 0);
        check("rst in_ready", a_ir, 0);
        check("rst c busy", c_busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("idle in_ready", a_ir, 0);

        row_s(8'h01, 8'h03, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h02, 0, 0);
        e = '{8'h04, 8'h03, 8'h00, 0, 0, 0, 0, 0, 0};
        check_row("t1a", qa, 2, e);
        check_row("t1b", qb, 2, e);
        check("t1 lsw_err", a_lerr, 0);
        check("t1 latency a", done_cyc_a - acc_cyc, 5);
        check("t1 latency b", done_cyc_b - acc_cyc, 7);
        check("t1 busy after", a_busy, 0);

        row_s(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0);
        e = '{8'hFF, 8'hFE, 8'h00, 0, 0, 0, 0, 0, 0};
        check_row("t2a", qa, 2, e);
        check_row("t2b", qb, 2, e);
        check("t2 lsw_err", b_lerr, 0);

        row_s(8'h01, 8'h03, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h02, 3, 0);
        e = '{8'h04, 8'h03, 8'h00, 0, 0, 0, 0, 0, 0};
        check_row("t3a", qa, 2, e);
        check_row("t3b", qb, 2, e);

        row_s(8'h00, 8'h01, 8'h02, 8'h11, 8'h22, 8'h05, 8'h07, 0, 0);
        e = '{8'h07, 8'h01, 8'h02, 0, 0, 0, 0, 0, 0};
        check_row("t4a", qa, 2, e);
        check("t4 lsw_err held", a_lerr, 1);
        check("t4 lsw_err b", b_lerr, 1);

        // New start clears lsw_err, then reset aborts the row after its first word
        qa.delete();
        qb.delete();
        m = 8'h01; t_hi = 8'h03; t_hi1 = 8'h00; start_s = 1'b1;
        step();
        start_s = 1'b0;
        check("t4 lsw_err cleared", a_lerr, 0);
        check("t5 busy", a_busy, 1);
        iv_s = 1'b1; t_in = 8'h01; p_in = 8'hFF;
        step();
        iv_s = 1'b0;
        rst = 1'b1;
        #1;
        check("t5 out_valid", a_ov, 0);
        check("t5 out_word", a_w, 0);
        check("t5 busy", a_busy, 0);
        check("t5 done", a_done, 0);
        check("t5 in_ready", a_ir, 0);
        check("t5 b busy", b_busy, 0);
        repeat (2) step();
        rst = 1'b0;
        repeat (8) step();
        check("t5 no outputs a", qa.size(), 0);
        check("t5 no outputs b", qb.size(), 0);

        row_s(8'h01, 8'h03, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h02, 0, 0);
        e = '{8'h04, 8'h03, 8'h00, 0, 0, 0, 0, 0, 0};
        check_row("t5 rerun", qa, 2, e);

        row_s(8'h01, 8'h03, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h02, 1, 1);
        check_row("t6a", qa, 2, e);
        check_row("t6b", qb, 2, e);
        check("t6 idle after", a_busy, 0);

        for (int r = 0; r < 8; r++) row_c(r[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
